// File: rtl/poly_stream_buffer_pkg.sv
// Shared types and constants for the polynomial stream buffer.
package poly_pkg;
  localparam int POLY_N      = 256;
  localparam int DILITHIUM_Q = 8380417;

  typedef logic signed [31:0] coeff_t;

  typedef enum logic [1:0] {
    EMPTY,
    CAPTURE,
    FULL,
    TX
  } buf_state_e;
endpackage

// File: rtl/poly_stream_buffer_if.sv
// Capture/replay stream bundle of the polynomial buffer.
// master drives capture beats and the replay request; slave is the buffer.
interface poly_stream_buffer_if #(
  parameter int W = 32
);
  logic                i_valid;
  logic signed [W-1:0] i_data;
  logic                i_tx_start;
  logic                o_full;
  logic                o_busy;
  logic                o_tx_ready;
  logic signed [W-1:0] o_tx_data;
  logic                o_overflow;

  modport master (
    output i_valid, i_data, i_tx_start,
    input  o_full, o_busy, o_tx_ready, o_tx_data, o_overflow
  );

  modport slave (
    input  i_valid, i_data, i_tx_start,
    output o_full, o_busy, o_tx_ready, o_tx_data, o_overflow
  );
endinterface

// File: rtl/poly_stream_buffer_coeff_ram.sv
// N x W simple dual-port coefficient RAM: one synchronous write port and one
// synchronous read port with 1-cycle latency. No reset so it maps to BRAM/SRAM.
module coeff_ram #(
  parameter int N  = 256,
  parameter int W  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [N];
  logic [W-1:0] rd_data_q;

  // Write port
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port
  always_ff @(posedge i_clk) begin
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/poly_stream_buffer.sv
// Captures one N-coefficient polynomial from a producer stream and replays it
// as a gap-free N-beat stream on request.
// Optional feature macro POLY_FREEZE_EN: reduce each captured coefficient from
// (-Q,2Q) to [0,Q) before it is written; undefined stores data unchanged.
module poly_stream_buffer
  import poly_pkg::*;
#(
  parameter int N = POLY_N,
  parameter int W = 32
) (
  input logic                 i_clk,
  input logic                 i_rst,
  poly_stream_buffer_if.slave bus
);
  localparam int            AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  buf_state_e    state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          tx_ready_q, tx_ready_d;
  logic          overflow_q, overflow_d;
  logic          wr_en, rd_en;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data;

  // Coefficient conditioning ahead of the RAM write port
  always_comb begin
    wr_data = bus.i_data;
`ifdef POLY_FREEZE_EN
    if (bus.i_data[W-1])
      wr_data = bus.i_data + W'(DILITHIUM_Q);
    else if (bus.i_data >= W'(DILITHIUM_Q))
      wr_data = bus.i_data - W'(DILITHIUM_Q);
`endif
  end

  // Next-state, counters and RAM strobes. The read for beat k is issued one
  // cycle before beat k shows up, so the start cycle already reads address 0.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    tx_ready_d = 1'b0;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.i_valid) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.i_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            state_d  = FULL;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (bus.i_tx_start) begin
          overflow_d = 1'b0;
          rd_en      = 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
          tx_ready_d = 1'b1;
          state_d    = TX;
        end
        // A dropped beat in the same cycle as the start still flags
        if (bus.i_valid) overflow_d = 1'b1;
      end
      TX: begin
        // rd_cnt back at 0 means the last beat is on the output right now
        if (rd_cnt_q == '0) begin
          state_d = EMPTY;
        end else begin
          rd_en      = 1'b1;
          rd_cnt_d   = (rd_cnt_q == LAST) ? '0 : rd_cnt_q + 1'b1;
          tx_ready_d = 1'b1;
        end
        if (bus.i_valid) overflow_d = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= EMPTY;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      tx_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_ready_q <= tx_ready_d;
      overflow_q <= overflow_d;
    end
  end

  coeff_ram #(.N(N), .W(W), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt_q),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data)
  );

  // RAM output is unreset, so mask it to keep the data bus 0 when idle
  assign bus.o_tx_data  = tx_ready_q ? rd_data : '0;
  assign bus.o_tx_ready = tx_ready_q;
  assign bus.o_full     = (state_q == FULL);
  assign bus.o_busy     = (state_q == CAPTURE) || (state_q == TX);
  assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_poly_stream_buffer.sv
// Directed bench for poly_stream_buffer: capture, replay, gaps, overflow,
// mid-operation reset and the optional freeze reduction.
module tb_poly_stream_buffer;
  import poly_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     vectors = 0;
  int     miscompares = 0;
  coeff_t exp_mem [256];

  poly_stream_buffer_if #(.W(32)) bus ();

  poly_stream_buffer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Feed exp_mem[0..n-1]; optional gap pattern and start pulse on the last beat
  task automatic capture(input int n, input bit gaps, input bit start_last);
    for (int k = 0; k < n; k++) begin
      if (gaps && (((k * 37) >> 2) & 1) == 1) begin
        bus.i_valid = 1'b0;
        @(negedge clk);
      end
      if (n == 256 && k == 255) begin
        vectors++;
        if (bus.o_full !== 1'b0 || bus.o_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL pre_last_beat: full=%b busy=%b expected full=0 busy=1", bus.o_full, bus.o_busy);
        end
        bus.i_tx_start = start_last;
      end
      bus.i_valid = 1'b1;
      bus.i_data  = exp_mem[k];
      @(negedge clk);
      bus.i_valid    = 1'b0;
      bus.i_tx_start = 1'b0;
    end
  endtask

  // Pulse start and check all 256 replay beats against exp_mem
  task automatic replay_check(input string name);
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    vectors++;
    if (bus.o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ovf_clear: got %b expected 0", name, bus.o_overflow);
    end
    for (int k = 0; k < 256; k++) begin
      vectors++;
      if (bus.o_tx_ready !== 1'b1 || bus.o_tx_data !== exp_mem[k]) begin
        miscompares++;
        $display("FAIL %s beat %0d: ready=%b data=%0d expected ready=1 data=%0d",
                 name, k, bus.o_tx_ready, bus.o_tx_data, exp_mem[k]);
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.o_tx_ready !== 1'b0 || bus.o_full !== 1'b0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_end: ready=%b full=%b busy=%b expected all 0",
               name, bus.o_tx_ready, bus.o_full, bus.o_busy);
    end
  endtask

  task automatic test_reset;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_tx_start = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.o_tx_ready, bus.o_full, bus.o_busy, bus.o_overflow} !== 4'b0 || bus.o_tx_data !== 0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy/full/busy/ovf=%b data=%0d expected 0000 / 0",
               {bus.o_tx_ready, bus.o_full, bus.o_busy, bus.o_overflow}, bus.o_tx_data);
    end
    rst = 1'b0;
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    vectors++;
    if (bus.o_tx_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_empty: ready=%b busy=%b expected 0 0", bus.o_tx_ready, bus.o_busy);
    end
  endtask

  task automatic test_full_capture;
    for (int k = 0; k < 256; k++) exp_mem[k] = k;
    capture(256, 1'b0, 1'b0);
    vectors++;
    if (bus.o_full !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after_capture: full=%b busy=%b ovf=%b expected 1 0 0",
               bus.o_full, bus.o_busy, bus.o_overflow);
    end
  endtask

  task automatic test_replay;
    replay_check("replay_seq");
  endtask

  task automatic test_gap_capture;
    for (int k = 0; k < 256; k++) exp_mem[k] = k * 3 - 300;
    capture(256, 1'b1, 1'b1);
    vectors++;
    if (bus.o_full !== 1'b1 || bus.o_tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_on_last_beat: full=%b ready=%b expected 1 0", bus.o_full, bus.o_tx_ready);
    end
    @(negedge clk);
    vectors++;
    if (bus.o_tx_ready !== 1'b0 || bus.o_full !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ignored: ready=%b full=%b expected 0 1", bus.o_tx_ready, bus.o_full);
    end
    replay_check("gap_replay");
  endtask

  task automatic test_overflow;
    for (int k = 0; k < 256; k++) exp_mem[k] = 1000 + k;
    capture(256, 1'b0, 1'b0);
    bus.i_valid = 1'b1; bus.i_data = 7;
    @(negedge clk);
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_overflow !== 1'b1 || bus.o_full !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: ovf=%b full=%b expected 1 1", bus.o_overflow, bus.o_full);
    end
    @(negedge clk);
    vectors++;
    if (bus.o_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %b expected 1", bus.o_overflow);
    end
    replay_check("overflow_replay");
  endtask

  task automatic test_reset_mid_capture;
    for (int k = 0; k < 256; k++) exp_mem[k] = 77;
    capture(100, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.o_tx_ready !== 1'b0 || bus.o_full !== 1'b0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_capture: ready=%b full=%b busy=%b expected 0 0 0",
               bus.o_tx_ready, bus.o_full, bus.o_busy);
    end
    for (int k = 0; k < 256; k++) exp_mem[k] = 255 - k;
    capture(256, 1'b0, 1'b0);
    replay_check("after_rst_capture");
  endtask

  task automatic test_reset_mid_tx;
    for (int k = 0; k < 256; k++) exp_mem[k] = k * 5;
    capture(256, 1'b0, 1'b0);
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (bus.o_tx_ready !== 1'b1 || bus.o_tx_data !== exp_mem[k]) begin
        miscompares++;
        $display("FAIL pre_rst_tx beat %0d: ready=%b data=%0d expected 1 %0d",
                 k, bus.o_tx_ready, bus.o_tx_data, exp_mem[k]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.o_tx_ready !== 1'b0 || bus.o_full !== 1'b0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_tx: ready=%b full=%b busy=%b expected 0 0 0",
               bus.o_tx_ready, bus.o_full, bus.o_busy);
    end
    for (int k = 0; k < 256; k++) exp_mem[k] = -k;
    capture(256, 1'b0, 1'b0);
    replay_check("after_rst_tx");
  endtask

  task automatic test_freeze;
    coeff_t raw [4];
    raw[0] = -1; raw[1] = 8380417; raw[2] = 8380416; raw[3] = -8380416;
    for (int k = 0; k < 256; k++) exp_mem[k] = k;
    for (int k = 0; k < 4; k++) exp_mem[k] = raw[k];
    capture(256, 1'b0, 1'b0);
`ifdef POLY_FREEZE_EN
    exp_mem[0] = 8380416; exp_mem[1] = 0; exp_mem[2] = 8380416; exp_mem[3] = 1;
`endif
    replay_check("freeze_values");
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_replay();
    test_gap_capture();
    test_overflow();
    test_reset_mid_capture();
    test_reset_mid_tx();
    test_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
